vdp_reg_write_arbiter: RTL and testbench

VDP_REG_WRITE_ARBITER -- requirements
Module: vdp_reg_write_arbiter

---
 rtl/vdp_reg_write_arbiter.sv | 122 ++++++++++++
 tb/tb_vdp_reg_write_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_reg_write_arbiter.sv
// VDP register write arbiter: copper FIFO (4 deep) and host holding register share one register-file write port.
// Optional VDP_REG_ARB_STATS_EN adds stat_clear / stat_write_count (committed-write counter).
module vdp_reg_write_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  copper_write_address,
   input  logic [15:0] copper_write_data,
   input  logic        copper_write_en,
   output logic        copper_write_ready,
   input  logic [5:0]  host_write_address,
   input  logic [15:0] host_write_data,
   input  logic        host_write_en,
   output logic        host_write_ready,
   input  logic        reg_stall,
   output logic [5:0]  reg_write_address,
   output logic [15:0] reg_write_data,
   output logic        reg_write_en,
   output logic        reg_write_source,
`ifdef VDP_REG_ARB_STATS_EN
   input  logic        stat_clear,
   output logic [15:0] stat_write_count,
`endif
   output logic        copper_overflow
);

   logic [21:0] fifo_mem [4];
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;
   logic [2:0]  count;

   logic        host_valid;
   logic [5:0]  host_addr;
   logic [15:0] host_data;
   logic [2:0]  starve;

   logic        enq;
   logic        grant_host;
   logic        grant_copper;

   assign copper_write_ready = (count != 3'd4);
   assign host_write_ready   = !host_valid;

   // Copper wins unless the host has waited long enough to saturate its starvation counter.
   always_comb begin
      enq          = copper_write_en && copper_write_ready;
      grant_host   = 1'b0;
      grant_copper = 1'b0;
      if (!reg_stall) begin
         grant_host   = host_valid && ((count == 3'd0) || (starve == 3'd7));
         grant_copper = (count != 3'd0) && !grant_host;
      end
   end

   always_ff @(posedge clk) begin
      if (enq)
         fifo_mem[wr_ptr] <= {copper_write_address, copper_write_data};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         count             <= '0;
         host_valid        <= 1'b0;
         host_addr         <= '0;
         host_data         <= '0;
         starve            <= '0;
         copper_overflow   <= 1'b0;
         reg_write_en      <= 1'b0;
         reg_write_address <= '0;
         reg_write_data    <= '0;
         reg_write_source  <= 1'b0;
      end else begin
         if (enq)
            wr_ptr <= wr_ptr + 2'd1;
         if (grant_copper)
            rd_ptr <= rd_ptr + 2'd1;
         case ({enq, grant_copper})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase

         if (copper_write_en && !copper_write_ready)
            copper_overflow <= 1'b1;

         if (grant_host) begin
            host_valid <= 1'b0;
         end else if (host_write_en && !host_valid) begin
            host_valid <= 1'b1;
            host_addr  <= host_write_address;
            host_data  <= host_write_data;
         end

         // Stalled cycles count as waiting too.
         if (!host_valid || grant_host)
            starve <= '0;
         else if (starve != 3'd7)
            starve <= starve + 3'd1;

         reg_write_en <= grant_host || grant_copper;
         if (grant_host) begin
            reg_write_address <= host_addr;
            reg_write_data    <= host_data;
            reg_write_source  <= 1'b1;
         end else if (grant_copper) begin
            {reg_write_address, reg_write_data} <= fifo_mem[rd_ptr];
            reg_write_source                    <= 1'b0;
         end
      end
   end

`ifdef VDP_REG_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (reset || stat_clear)
         stat_write_count <= '0;
      else if (reg_write_en)
         stat_write_count <= stat_write_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_vdp_reg_write_arbiter.sv
// Self-checking bench for vdp_reg_write_arbiter: table of single-write vectors plus directed
// sequences for FIFO overflow, same-cycle arbitration, starvation and mid-operation reset.
module tb_vdp_reg_write_arbiter;

   logic        clk;
   logic        reset;
   logic [5:0]  copper_write_address;
   logic [15:0] copper_write_data;
   logic        copper_write_en;
   logic        copper_write_ready;
   logic [5:0]  host_write_address;
   logic [15:0] host_write_data;
   logic        host_write_en;
   logic        host_write_ready;
   logic        reg_stall;
   logic [5:0]  reg_write_address;
   logic [15:0] reg_write_data;
   logic        reg_write_en;
   logic        reg_write_source;
   logic        copper_overflow;
`ifdef VDP_REG_ARB_STATS_EN
   logic        stat_clear;
   logic [15:0] stat_write_count;
`endif

   vdp_reg_write_arbiter dut (
      .clk                  (clk),
      .reset                (reset),
      .copper_write_address (copper_write_address),
      .copper_write_data    (copper_write_data),
      .copper_write_en      (copper_write_en),
      .copper_write_ready   (copper_write_ready),
      .host_write_address   (host_write_address),
      .host_write_data      (host_write_data),
      .host_write_en        (host_write_en),
      .host_write_ready     (host_write_ready),
      .reg_stall            (reg_stall),
      .reg_write_address    (reg_write_address),
      .reg_write_data       (reg_write_data),
      .reg_write_en         (reg_write_en),
      .reg_write_source     (reg_write_source),
`ifdef VDP_REG_ARB_STATS_EN
      .stat_clear           (stat_clear),
      .stat_write_count     (stat_write_count),
`endif
      .copper_overflow      (copper_overflow)
   );

   typedef struct {
      logic        is_host;
      logic [5:0]  addr;
      logic [15:0] data;
      int unsigned stall;
      int unsigned lat;
   } vec_t;

   vec_t        vecs [6];
   logic [21:0] cq [$];
   logic [21:0] hq [$];
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) tick();
   endtask

   // Commit scoreboard: each committed write must match the oldest expected entry of its source.
   always @(negedge clk) begin
      if (!reset && reg_write_en) begin
         if (reg_write_source) begin
            if (hq.size() == 0) check("host_unexpected_commit", 1, 0);
            else check("host_commit_payload", {reg_write_address, reg_write_data}, hq.pop_front());
         end else begin
            if (cq.size() == 0) check("copper_unexpected_commit", 1, 0);
            else check("copper_commit_payload", {reg_write_address, reg_write_data}, cq.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 6'h05, 16'hBEEF, 0, 2};
      vecs[1] = '{1'b1, 6'h3F, 16'hFFFF, 0, 2};
      vecs[2] = '{1'b0, 6'h00, 16'h0000, 1, 3};
      vecs[3] = '{1'b1, 6'h2A, 16'h1234, 3, 5};
      vecs[4] = '{1'b0, 6'h3F, 16'hA5A5, 2, 4};
      vecs[5] = '{1'b1, 6'h01, 16'h0001, 0, 2};

      reset                = 1'b1;
      copper_write_address = '0;
      copper_write_data    = '0;
      copper_write_en      = 1'b0;
      host_write_address   = '0;
      host_write_data      = '0;
      host_write_en        = 1'b0;
      reg_stall            = 1'b0;
`ifdef VDP_REG_ARB_STATS_EN
      stat_clear           = 1'b0;
`endif
      idle(3);
      reset = 1'b0;
      tick();
      check("rst_reg_write_en", reg_write_en, 0);
      check("rst_reg_write_address", reg_write_address, 0);
      check("rst_reg_write_data", reg_write_data, 0);
      check("rst_reg_write_source", reg_write_source, 0);
      check("rst_copper_overflow", copper_overflow, 0);
      check("rst_copper_ready", copper_write_ready, 1);
      check("rst_host_ready", host_write_ready, 1);
`ifdef VDP_REG_ARB_STATS_EN
      check("rst_stat_count", stat_write_count, 0);
`endif
      idle(6);

      // Single writes with a stall window on cycles 1..stall after the strobe.
      for (int i = 0; i < 6; i++) begin
         if (vecs[i].is_host) begin
            host_write_address = vecs[i].addr;
            host_write_data    = vecs[i].data;
            host_write_en      = 1'b1;
            hq.push_back({vecs[i].addr, vecs[i].data});
         end else begin
            copper_write_address = vecs[i].addr;
            copper_write_data    = vecs[i].data;
            copper_write_en      = 1'b1;
            cq.push_back({vecs[i].addr, vecs[i].data});
         end
         reg_stall = 1'b0;
         for (int unsigned k = 1; k <= vecs[i].lat + 1; k++) begin
            tick();
            copper_write_en = 1'b0;
            host_write_en   = 1'b0;
            reg_stall       = (k <= vecs[i].stall);
            check($sformatf("vec%0d_en_k%0d", i, k), reg_write_en, (k == vecs[i].lat));
            check($sformatf("vec%0d_host_ready_k%0d", i, k), host_write_ready,
                  !(vecs[i].is_host && (k < vecs[i].lat)));
            if (k == vecs[i].lat)
               check($sformatf("vec%0d_source", i), reg_write_source, vecs[i].is_host);
            if (k == vecs[i].lat + 1)
               check($sformatf("vec%0d_hold", i), {reg_write_address, reg_write_data},
                     {vecs[i].addr, vecs[i].data});
         end
         idle(2);
      end

      // Host and copper strobe together: copper commits first, host next.
      copper_write_address = 6'h11; copper_write_data = 16'h1111; copper_write_en = 1'b1;
      host_write_address   = 6'h22; host_write_data   = 16'h2222; host_write_en   = 1'b1;
      cq.push_back({6'h11, 16'h1111});
      hq.push_back({6'h22, 16'h2222});
      for (int unsigned k = 1; k <= 4; k++) begin
         tick();
         copper_write_en = 1'b0;
         host_write_en   = 1'b0;
         check($sformatf("both_en_k%0d", k), reg_write_en, (k == 2 || k == 3));
         if (k == 2) check("both_first_source", reg_write_source, 0);
         if (k == 3) check("both_second_source", reg_write_source, 1);
         check($sformatf("both_host_ready_k%0d", k), host_write_ready, (k >= 3));
      end
      idle(3);

      // Continuous copper traffic: each host write wins on its 8th pending cycle.
      for (int unsigned k = 0; k <= 19; k++) begin
         if (k > 0) tick();
         if (k >= 2) begin
            check($sformatf("starve_en_k%0d", k), reg_write_en, 1);
            check($sformatf("starve_source_k%0d", k), reg_write_source, (k == 9 || k == 18));
         end
         if (k == 0 || k == 9)
            check($sformatf("starve_host_ready_k%0d", k), host_write_ready, 1);
         copper_write_en      = (k <= 18);
         copper_write_address = 6'(k);
         copper_write_data    = 16'hC000 + 16'(k);
         if (k <= 18) cq.push_back({6'(k), 16'hC000 + 16'(k)});
         host_write_en = (k == 0 || k == 9);
         if (k == 0 || k == 9) begin
            host_write_address = 6'h30 + 6'(k);
            host_write_data    = 16'h4000 + 16'(k);
            hq.push_back({6'h30 + 6'(k), 16'h4000 + 16'(k)});
         end
      end
      tick();
      copper_write_en = 1'b0;
      host_write_en   = 1'b0;
      idle(8);
      check("starve_drained_copper", cq.size(), 0);
      check("starve_drained_host", hq.size(), 0);

      // Six strobes into a stalled FIFO: two dropped, overflow sticky, four ordered commits.
      for (int unsigned k = 0; k <= 11; k++) begin
         if (k > 0) tick();
         if (k <= 5) check($sformatf("ovf_ready_k%0d", k), copper_write_ready, (k < 4));
         if (k <= 6) check($sformatf("ovf_flag_k%0d", k), copper_overflow, (k >= 5));
         check($sformatf("ovf_en_k%0d", k), reg_write_en, (k >= 7 && k <= 10));
         reg_stall            = (k <= 5);
         copper_write_en      = (k <= 5);
         copper_write_address = 6'h20 + 6'(k);
         copper_write_data    = 16'hD000 + 16'(k);
         if (k < 4) cq.push_back({6'h20 + 6'(k), 16'hD000 + 16'(k)});
      end
      check("ovf_flag_sticky", copper_overflow, 1);
      check("ovf_drained", cq.size(), 0);
      idle(2);

      // Reset with three copper entries and a host entry pending discards everything.
      for (int unsigned k = 0; k <= 3; k++) begin
         if (k > 0) tick();
         reg_stall            = 1'b1;
         copper_write_en      = (k <= 2);
         copper_write_address = 6'h0A + 6'(k);
         copper_write_data    = 16'hE000 + 16'(k);
         host_write_en        = (k == 0);
         host_write_address   = 6'h1B;
         host_write_data      = 16'h5555;
      end
      check("rstmid_count_full_pre", copper_write_ready, 1);
      check("rstmid_host_pending_pre", host_write_ready, 0);
      reset = 1'b1;
      tick();
      reset     = 1'b0;
      reg_stall = 1'b0;
      check("rstmid_copper_ready", copper_write_ready, 1);
      check("rstmid_host_ready", host_write_ready, 1);
      check("rstmid_overflow", copper_overflow, 0);
      for (int unsigned k = 0; k < 5; k++) begin
         check($sformatf("rstmid_no_commit_k%0d", k), reg_write_en, 0);
         tick();
      end

`ifdef VDP_REG_ARB_STATS_EN
      stat_clear = 1'b1;
      tick();
      stat_clear = 1'b0;
      check("stat_cleared", stat_write_count, 0);
      for (int unsigned k = 0; k <= 5; k++) begin
         if (k > 0) tick();
         copper_write_en      = (k <= 2);
         copper_write_address = 6'h38 + 6'(k);
         copper_write_data    = 16'hF000 + 16'(k);
         if (k <= 2) cq.push_back({6'h38 + 6'(k), 16'hF000 + 16'(k)});
      end
      check("stat_three_commits", stat_write_count, 3);
      copper_write_address = 6'h3C; copper_write_data = 16'hF0F0; copper_write_en = 1'b1;
      cq.push_back({6'h3C, 16'hF0F0});
      tick();
      copper_write_en = 1'b0;
      tick();
      check("stat_clear_commit_en", reg_write_en, 1);
      stat_clear = 1'b1;
      tick();
      stat_clear = 1'b0;
      check("stat_clear_priority", stat_write_count, 0);
      idle(2);
`endif

      check("final_copper_queue_empty", cq.size(), 0);
      check("final_host_queue_empty", hq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
